// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the execute-stage issue logic and the
// iterative RV32M multiply/divide unit.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr_in;
  logic            busy;
  logic            done;
  logic            wb_en;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_addr_out;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_addr_in,
    input  busy, done, wb_en, result, rd_addr_out
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_addr_in,
    output busy, done, wb_en, result, rd_addr_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst_n,
  ex_muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (-x) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] x, input logic neg);
    return neg ? (-x) : x;
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [4:0]          rd_q, rd_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode at accept: signedness, magnitudes and the no-iteration cases
  logic            a_sgn, b_sgn;
  logic            in_sa, in_sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            in_div_zero, in_ovf, in_special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.funct3)
      F_MULH, F_DIV, F_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      F_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign in_sa = a_sgn & bus.rs1_data[XLEN-1];
  assign in_sb = b_sgn & bus.rs2_data[XLEN-1];
  assign mag_a = neg_if(bus.rs1_data, in_sa);
  assign mag_b = neg_if(bus.rs2_data, in_sb);

  assign in_div_zero = bus.funct3[2] && (bus.rs2_data == '0);
  assign in_ovf      = bus.funct3[2] && !bus.funct3[0] &&
                       (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
  assign in_special  = in_div_zero || in_ovf;

  always_comb begin
    special_res = '0;
    if (in_div_zero) special_res = bus.funct3[1] ? bus.rs1_data : '1;
    else             special_res = bus.funct3[1] ? '0 : INT_MIN;
  end

  // One iteration step: multiply adds the multiplicand when the low bit is set,
  // divide shifts the next dividend bit into the remainder and trial-subtracts.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [XLEN:0]     rem_next;
  logic [XLEN-1:0]   quo_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign rem_sh   = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, opb_q};
  assign div_ok   = !div_diff[XLEN+1];
  assign rem_next = div_ok ? div_diff[XLEN:0] : rem_sh;
  assign quo_next = {acc_q[XLEN-2:0], div_ok};

  // Sign correction and output-word selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_fix = neg_if_wide(acc_q, sa_q ^ sb_q);
  assign quo_fix  = neg_if(acc_q[XLEN-1:0], sa_q ^ sb_q);
  assign rem_fix  = neg_if(rem_q[XLEN-1:0], sa_q);

  always_comb begin
    fix_res = '0;
    case (op_q)
      F_MUL:                      fix_res = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              fix_res = quo_fix;
      F_REM, F_REMU:              fix_res = rem_fix;
      default:                    fix_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          op_d = bus.funct3;
          rd_d = bus.rd_addr_in;
          sa_d = in_sa;
          sb_d = in_sb;
          if (in_special) begin
            result_d = special_res;
            rd_out_d = bus.rd_addr_in;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
            cnt_d   = CW'(XLEN);
            rem_d   = '0;
            // Divide keeps the divisor in opb and shifts the dividend out of acc;
            // multiply keeps the multiplicand in opb and the multiplier in acc.
            opb_d   = bus.funct3[2] ? mag_b : mag_a;
            acc_d   = {{XLEN{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q[2]) begin
          acc_d = {acc_q[2*XLEN-1:XLEN], quo_next};
          rem_d = rem_next;
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == CW'(1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        result_d = fix_res;
        rd_out_d = rd_q;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

  assign bus.busy        = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign bus.done        = (state_q == S_DONE);
  assign bus.wb_en       = (state_q == S_DONE) && (rd_out_q != 5'd0);
  assign bus.result      = result_q;
  assign bus.rd_addr_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, randomized ops
// against an arithmetic reference model, and busy/back-to-back/reset scenarios.
module tb_ex_muldiv_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex_muldiv_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint     sa;
    longint     sb;
    longint     ua;
    longint     ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge: presents one request across the next rising edge,
  // then scrambles the operand inputs so late changes would be noticed.
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    bus.start      = 1'b1;
    bus.funct3     = f3;
    bus.rs1_data   = a;
    bus.rs2_data   = b;
    bus.rd_addr_in = rd;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.funct3     = 3'($urandom);
    bus.rs1_data   = $urandom;
    bus.rs2_data   = $urandom;
    bus.rd_addr_in = 5'($urandom);
  endtask

  // Waits (bounded) for done; optionally pulses an illegal start at cycle poke.
  task automatic wait_done(input int poke, output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      if (lat == poke) begin
        bus.start      = 1'b1;
        bus.funct3     = 3'b101;
        bus.rs1_data   = 32'd5;
        bus.rs2_data   = 32'd0;
        bus.rd_addr_in = 5'd3;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.funct3     = 3'd0;
    bus.rs1_data   = 32'd0;
    bus.rs2_data   = 32'd0;
    bus.rd_addr_in = 5'd0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got=%b exp=0", bus.wb_en); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    checks++; if (bus.rd_addr_out !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", bus.rd_addr_out); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  f3 [12];
    logic [31:0] a  [12];
    logic [31:0] b  [12];
    logic [31:0] ex [12];
    int          el [12];
    int          lat;
    int          bcnt;
    logic [4:0]  rd;
    f3[0]  = 3'd0; a[0]  = 32'd7;          b[0]  = 32'd6;          ex[0]  = 32'd42;         el[0]  = 34;
    f3[1]  = 3'd1; a[1]  = 32'hFFFF_FFFF;  b[1]  = 32'hFFFF_FFFF;  ex[1]  = 32'd0;          el[1]  = 34;
    f3[2]  = 3'd3; a[2]  = 32'hFFFF_FFFF;  b[2]  = 32'hFFFF_FFFF;  ex[2]  = 32'hFFFF_FFFE;  el[2]  = 34;
    f3[3]  = 3'd2; a[3]  = 32'hFFFF_FFFF;  b[3]  = 32'd2;          ex[3]  = 32'hFFFF_FFFF;  el[3]  = 34;
    f3[4]  = 3'd4; a[4]  = 32'hFFFF_FFF9;  b[4]  = 32'd2;          ex[4]  = 32'hFFFF_FFFD;  el[4]  = 34;
    f3[5]  = 3'd6; a[5]  = 32'hFFFF_FFF9;  b[5]  = 32'd2;          ex[5]  = 32'hFFFF_FFFF;  el[5]  = 34;
    f3[6]  = 3'd5; a[6]  = 32'd100;        b[6]  = 32'd7;          ex[6]  = 32'd14;         el[6]  = 34;
    f3[7]  = 3'd7; a[7]  = 32'd100;        b[7]  = 32'd7;          ex[7]  = 32'd2;          el[7]  = 34;
    f3[8]  = 3'd5; a[8]  = 32'd5;          b[8]  = 32'd0;          ex[8]  = 32'hFFFF_FFFF;  el[8]  = 1;
    f3[9]  = 3'd6; a[9]  = 32'd5;          b[9]  = 32'd0;          ex[9]  = 32'd5;          el[9]  = 1;
    f3[10] = 3'd4; a[10] = 32'h8000_0000;  b[10] = 32'hFFFF_FFFF;  ex[10] = 32'h8000_0000;  el[10] = 1;
    f3[11] = 3'd6; a[11] = 32'h8000_0000;  b[11] = 32'hFFFF_FFFF;  ex[11] = 32'd0;          el[11] = 1;
    for (int i = 0; i < 12; i++) begin
      rd = (i == 0) ? 5'd5 : 5'(i + 1);
      launch(f3[i], a[i], b[i], rd);
      wait_done(0, lat, bcnt);
      checks++; if (bus.result !== ex[i]) begin
        errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, bus.result, ex[i]);
      end
      checks++; if (lat != el[i]) begin
        errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el[i]);
      end
      checks++; if (bcnt != ((el[i] == 34) ? 33 : 0)) begin
        errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bcnt, (el[i] == 34) ? 33 : 0);
      end
      checks++; if (bus.rd_addr_out !== rd || bus.wb_en !== 1'b1 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL dir%0d_wb rd=%0d wb_en=%b busy=%b exp rd=%0d wb_en=1 busy=0",
                           i, bus.rd_addr_out, bus.wb_en, bus.busy, rd);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    int          lat;
    int          bcnt;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom);
      exp_res = ref_model(f3, a, b);
      launch(f3, a, b, rd);
      wait_done(0, lat, bcnt);
      checks++; if (bus.result !== exp_res) begin
        errors++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h got=%h exp=%h", i, f3, a, b, bus.result, exp_res);
      end
      checks++; if (lat != ref_latency(f3, a, b)) begin
        errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, ref_latency(f3, a, b));
      end
      checks++; if (bus.wb_en !== (rd != 5'd0) || bus.rd_addr_out !== rd) begin
        errors++; $display("FAIL rnd%0d_wb wb_en=%b rd=%0d exp wb_en=%b rd=%0d", i, bus.wb_en, bus.rd_addr_out, rd != 5'd0, rd);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_rd_zero();
    int lat;
    int bcnt;
    launch(3'd0, 32'd3, 32'd4, 5'd0);
    wait_done(0, lat, bcnt);
    checks++; if (bus.done !== 1'b1 || bus.wb_en !== 1'b0) begin
      errors++; $display("FAIL rd_zero done=%b wb_en=%b exp 1/0", bus.done, bus.wb_en);
    end
    checks++; if (bus.result !== 32'd12) begin
      errors++; $display("FAIL rd_zero_result got=%h exp=%h", bus.result, 32'd12);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int lat;
    int bcnt;
    launch(3'd0, 32'd123456, 32'd789, 5'd7);
    wait_done(10, lat, bcnt);
    checks++; if (bus.result !== 32'd97406784 || bus.rd_addr_out !== 5'd7) begin
      errors++; $display("FAIL busy_ignore result=%h rd=%0d exp=%h rd=7", bus.result, bus.rd_addr_out, 32'd97406784);
    end
    checks++; if (lat != 34) begin
      errors++; $display("FAIL busy_ignore_latency got=%0d exp=34", lat);
    end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin
      errors++; $display("FAIL busy_ignore_single_done got=%b exp=0", bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    int          bcnt;
    logic [31:0] e1;
    logic [31:0] e2;
    e1 = ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    e2 = ref_model(3'd4, 32'hFFFF_0000, 32'd291);
    launch(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd4);
    wait_done(0, lat, bcnt);
    checks++; if (bus.result !== e1) begin
      errors++; $display("FAIL b2b_first got=%h exp=%h", bus.result, e1);
    end
    launch(3'd4, 32'hFFFF_0000, 32'd291, 5'd6);
    wait_done(0, lat, bcnt);
    checks++; if (lat != 34) begin
      errors++; $display("FAIL b2b_latency got=%0d exp=34", lat);
    end
    checks++; if (bus.result !== e2 || bus.rd_addr_out !== 5'd6) begin
      errors++; $display("FAIL b2b_second result=%h rd=%0d exp=%h rd=6", bus.result, bus.rd_addr_out, e2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int dones;
    int lat;
    int bcnt;
    launch(3'd4, 32'd1000, 32'd3, 5'd9);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wb_en !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctrl busy=%b done=%b wb_en=%b exp 0/0/0", bus.busy, bus.done, bus.wb_en);
    end
    checks++; if (bus.result !== 32'd0 || bus.rd_addr_out !== 5'd0) begin
      errors++; $display("FAIL mid_reset_data result=%h rd=%0d exp 0/0", bus.result, bus.rd_addr_out);
    end
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin
      errors++; $display("FAIL mid_reset_no_done got=%0d exp=0", dones);
    end
    launch(3'd7, 32'd1000, 32'd3, 5'd9);
    wait_done(0, lat, bcnt);
    checks++; if (bus.result !== 32'd1 || lat != 34) begin
      errors++; $display("FAIL post_reset_op result=%h lat=%0d exp=1 lat=34", bus.result, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_rd_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID-stage register file.
- Consumes `rs1_data`/`rs2_data` plus the destination address for one M-extension instruction.
- Computes the result over multiple cycles while holding `busy` to stall the pipeline.
- Returns `result`, `rd_addr_out` and `wb_en` to the writeback path, which feeds the register file write port.

Parameters:
- XLEN, 32, operand/result width; the counter is $clog2(XLEN)+1 bits wide.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  XLEN  operand A / dividend
- rs2_data  in  XLEN  operand B / divisor
- rd_addr_in  in  5  destination register
- busy  out  1  high in CALC and FIXUP; stalls fetch/decode
- done  out  1  one-cycle pulse, result valid
- wb_en  out  1  equals done AND (rd_addr_out != 0)
- result  out  XLEN  final value, held until the next done
- rd_addr_out  out  5  rd captured at start, held

Behaviour:
- Reset: when rst_n=0 at a rising edge, state=IDLE and all state registers clear.
  - busy=0, done=0, wb_en=0, result=0, rd_addr_out=0.
  - Reset dominates any in-progress operation; the partial result is discarded with no done pulse.
- States: IDLE, CALC, FIXUP, DONE.
- Accept: start=1 in IDLE or DONE at edge E0 captures funct3, operands and rd_addr_in.
  - Operands are converted to magnitudes per op signedness and result signs are recorded.
  - MULHSU: rs1 is signed, rs2 is unsigned.
- Special cases (no iteration): next state is DONE, so done is high in the cycle after E0.
  - DIV/DIVU with divisor 0: quotient = all ones; REM/REMU return the dividend unchanged.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Normal path: IDLE→CALC at E0.
  - CALC lasts exactly XLEN cycles, with a down-counter loaded to XLEN at E0.
  - Multiply: radix-2 shift-add on magnitudes into a 2*XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle, remainder XLEN+1 bits wide.
- Counter reaching 0 moves CALC→FIXUP.
  - FIXUP applies two's-complement sign correction:
    - product sign = sA^sB;
    - quotient sign = sA^sB;
    - remainder sign = sA (dividend sign).
  - FIXUP selects the output word: MUL low half, MULH* high half.
- FIXUP→DONE.
  - In DONE: done=1, result updated, wb_en per rule, busy=0.
  - DONE→IDLE unless start=1, which begins a new op back-to-back.
- Latency: start at cycle 0 → done at cycle XLEN+2 (34) normal, cycle 1 special.
- start while busy=1 is ignored; captured operands are not disturbed.
- Operand inputs may change after E0 without effect.
- funct3 is fully decoded; there is no illegal encoding.
- result and rd_addr_out change only on DONE entry or reset.

Test Plan:
- MUL 7 × 6, rd=5, start at cycle 0 → busy cycles 1–33; done/wb_en at cycle 34; result=42, rd_addr_out=5.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000.
- MULHU same operands → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD, and REM → 0xFFFFFFFF.
- DIVU 100/7 → 14, and REMU → 2.
- DIVU 5/0 → done at cycle 1, result 0xFFFFFFFF; REM 5/0 → 5.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, done at cycle 1; REM → 0.
- rd=0 → done=1, wb_en=0.
- start pulsed at cycle 10 during a MUL → ignored, first result unchanged.
- start in the DONE cycle → second op's done 34 cycles later.
- rst_n=0 at cycle 15 mid-DIV → next cycle busy=0, done=0, result=0; no done ever for that op.
